// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: synthetic DVP (vsync/href/RGB565 byte) camera source with test patterns.
// Optional DVP_TX_LINE_TAG_EN replaces pixel 0 of each active line with {frame_cnt, y}.
module dvp_pattern_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 160,
  parameter int VSYNC_LINES = 4,
  parameter int V_BP        = 16,
  parameter int V_FP        = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       tx_en,
  input  logic [1:0] pattern_sel,
  output logic       dvp_vsync,
  output logic       dvp_href,
  output logic [7:0] dvp_data,
  output logic [7:0] frame_cnt,
  output logic       frame_done
);
  localparam int LP = 2 * H_ACTIVE + H_BLANK;
  localparam int HW = $clog2(LP);
  localparam int M1 = VSYNC_LINES > V_BP ? VSYNC_LINES : V_BP;
  localparam int M2 = V_ACTIVE > V_FP ? V_ACTIVE : V_FP;
  localparam int LW = $clog2((M1 > M2 ? M1 : M2) + 1);
  localparam logic [127:0] BARS = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                   16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;
  state_t state, state_nxt;
  logic [HW-1:0] hcnt;
  logic [LW-1:0] lcnt, last_line;
  logic [1:0] sel;
  logic line_end, state_end, href_d, done_d, y3;
  logic [15:0] x, pix, pix_t;
  logic [2:0] bar;
  logic [7:0] data_d;
  assign line_end = hcnt == HW'(LP - 1);
  always_comb begin
    last_line = state == VSYNC ? LW'(VSYNC_LINES - 1) :
                state == VBP ? LW'(V_BP - 1) :
                state == ACTIVE ? LW'(V_ACTIVE - 1) : LW'(V_FP - 1);
    state_end = state != IDLE && line_end && lcnt == last_line;
  end
  always_ff @(posedge sys_clk)
    state <= sys_rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = tx_en ? VSYNC : IDLE;
      VSYNC:   state_nxt = state_end ? VBP : VSYNC;
      VBP:     state_nxt = state_end ? ACTIVE : VBP;
      ACTIVE:  state_nxt = state_end ? VFP : ACTIVE;
      VFP:     state_nxt = state_end ? (tx_en ? VSYNC : IDLE) : VFP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state == IDLE) begin
      hcnt <= '0;
      lcnt <= '0;
    end else begin
      hcnt <= line_end ? '0 : hcnt + HW'(1);
      lcnt <= state_end ? '0 : line_end ? lcnt + LW'(1) : lcnt;
    end
  end
  // pattern is sampled only at frame starts so mid-frame changes are ignored
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      sel <= '0;
    else if (tx_en && (state == IDLE || (state == VFP && state_end)))
      sel <= pattern_sel;
  end
  always_comb begin
    x = 16'(hcnt >> 1);
    y3 = |(lcnt & LW'(8));
    bar = 3'(x / 16'(H_ACTIVE / 8));
    pix = sel == 2'd0 ? BARS[{bar, 4'b0} +: 16] :
          sel == 2'd1 ? x :
          sel == 2'd2 ? {frame_cnt, frame_cnt} : {16{x[3] ^ y3}};
`ifdef DVP_TX_LINE_TAG_EN
    pix_t = x == 16'd0 ? {frame_cnt, 8'(lcnt)} : pix;
`else
    pix_t = pix;
`endif
    href_d = state == ACTIVE && hcnt < HW'(2 * H_ACTIVE);
    data_d = href_d ? (hcnt[0] ? pix_t[7:0] : pix_t[15:8]) : 8'h00;
    done_d = state == VFP && state_end;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dvp_vsync  <= 1'b0;
      dvp_href   <= 1'b0;
      dvp_data   <= 8'h00;
      frame_cnt  <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      dvp_vsync  <= state == VSYNC;
      dvp_href   <= href_d;
      dvp_data   <= data_d;
      frame_cnt  <= frame_cnt + {7'd0, done_d};
      frame_done <= done_d;
    end
  end
endmodule
